// File: rtl/jtopll_pkg.sv
// Shared register map, FSM encoding and channel helpers for the OPLL write decoder.
package jtopll_pkg;

  localparam logic [7:0] ADDR_ORIG   = 8'h00;
  localparam logic [7:0] ADDR_RHY    = 8'h0E;
  localparam logic [7:0] ADDR_FNUMLO = 8'h10;
  localparam logic [7:0] ADDR_FNUMHI = 8'h20;
  localparam logic [7:0] ADDR_INST   = 8'h30;
  localparam int         NUM_CH      = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_AWAIT = 2'd1,
    ST_WZERO = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic original;
    logic fnumlo;
    logic fnumhi;
    logic inst;
  } up_t;

  // Channel index to {group[1:0], sub[2:0]}: group = c/3, sub = c%3.
  function automatic logic [4:0] chan_sel(input logic [3:0] c);
    logic [4:0] r;
    case (c)
      4'd0: r = {2'd0, 3'd0};
      4'd1: r = {2'd0, 3'd1};
      4'd2: r = {2'd0, 3'd2};
      4'd3: r = {2'd1, 3'd0};
      4'd4: r = {2'd1, 3'd1};
      4'd5: r = {2'd1, 3'd2};
      4'd6: r = {2'd2, 3'd0};
      4'd7: r = {2'd2, 3'd1};
      4'd8: r = {2'd2, 3'd2};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jtopll_addr_dec.sv
// Combinational map from a latched register address to strobe, group and sub-slot.
module jtopll_addr_dec
  import jtopll_pkg::*;
(
  input  logic [7:0] addr_i,
  output logic       up_original_o,
  output logic       up_fnumlo_o,
  output logic       up_fnumhi_o,
  output logic       up_inst_o,
  output logic       rhy_o,
  output logic [1:0] group_o,
  output logic [2:0] sub_o
);

  logic [4:0] ch_sel;
  logic       ch_ok;

  assign ch_sel = chan_sel(addr_i[3:0]);
  assign ch_ok  = addr_i[3:0] < 4'(NUM_CH);

  // Channel registers only exist for channels 0-8; everything else decodes to nothing.
  always_comb begin
    up_original_o = 1'b0;
    up_fnumlo_o   = 1'b0;
    up_fnumhi_o   = 1'b0;
    up_inst_o     = 1'b0;
    rhy_o         = 1'b0;
    group_o       = 2'd0;
    sub_o         = 3'd0;
    if (addr_i[7:3] == ADDR_ORIG[7:3]) begin
      up_original_o = 1'b1;
      sub_o         = addr_i[2:0];
    end else if (addr_i == ADDR_RHY) begin
      rhy_o = 1'b1;
    end else if (ch_ok) begin
      {group_o, sub_o} = ch_sel;
      case (addr_i[7:4])
        ADDR_FNUMLO[7:4]: up_fnumlo_o = 1'b1;
        ADDR_FNUMHI[7:4]: up_fnumhi_o = 1'b1;
        ADDR_INST[7:4]:   up_inst_o   = 1'b1;
        default:          {group_o, sub_o} = 5'd0;
      endcase
    end
  end

endmodule

// File: rtl/jtopll_wrdec.sv
// CPU write decoder: address/data port handling, busy timing and held update strobes.
module jtopll_wrdec
  import jtopll_pkg::*;
#(
  parameter int ADDR_WAIT = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       zero,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       addr,
  input  logic [7:0] din,
  output logic       busy,
  output logic [7:0] reg_din,
  output logic [1:0] sel_group,
  output logic [2:0] sel_sub,
  output logic       up_fnumlo,
  output logic       up_fnumhi,
  output logic       up_inst,
  output logic       up_original,
  output logic       rhy_en,
  output logic [4:0] rhy_kon
);

  localparam int CW = (ADDR_WAIT < 2) ? 1 : $clog2(ADDR_WAIT + 1);

  state_t      state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]  addr_q;
  logic [7:0]  reg_din_q;
  logic [1:0]  sel_group_q;
  logic [2:0]  sel_sub_q;
  up_t         up_q;
  logic        rhy_en_q;
  logic [4:0]  rhy_kon_q;
  logic        wr_q;
  logic        wr_d;
  logic        wev;

  up_t         dec_up;
  logic        dec_rhy;
  logic [1:0]  dec_group;
  logic [2:0]  dec_sub;

  // Bus write is level; an event is only its first active cycle.
  assign wr_d = ~cs_n & ~wr_n;
  assign wev  = wr_d & ~wr_q;

  jtopll_addr_dec u_dec (
    .addr_i        (addr_q),
    .up_original_o (dec_up.original),
    .up_fnumlo_o   (dec_up.fnumlo),
    .up_fnumhi_o   (dec_up.fnumhi),
    .up_inst_o     (dec_up.inst),
    .rhy_o         (dec_rhy),
    .group_o       (dec_group),
    .sub_o         (dec_sub)
  );

  // Write FSM; rhythm writes bypass the busy gate and never touch the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      reg_din_q   <= '0;
      sel_group_q <= '0;
      sel_sub_q   <= '0;
      up_q        <= '0;
      rhy_en_q    <= 1'b0;
      rhy_kon_q   <= '0;
      wr_q        <= 1'b0;
    end else begin
      wr_q <= wr_d;
      if (wev && addr && dec_rhy) begin
        rhy_en_q  <= din[5];
        rhy_kon_q <= din[4:0];
      end
      case (state_q)
        ST_IDLE: begin
          if (wev) begin
            if (!addr) begin
              addr_q  <= din;
              cnt_q   <= CW'(ADDR_WAIT);
              state_q <= ST_AWAIT;
            end else begin
              reg_din_q <= din;
              if (dec_up != '0) begin
                up_q        <= dec_up;
                sel_group_q <= dec_group;
                sel_sub_q   <= dec_sub;
                state_q     <= ST_WZERO;
              end
            end
          end
        end
        ST_AWAIT: begin
          if (cen) begin
            if (cnt_q <= CW'(1)) begin
              cnt_q   <= '0;
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
        end
        ST_WZERO: begin
          if (cen && zero) state_q <= ST_HOLD;
        end
        ST_HOLD: begin
          if (cen && zero) begin
            up_q    <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign reg_din     = reg_din_q;
  assign sel_group   = sel_group_q;
  assign sel_sub     = sel_sub_q;
  assign up_original = up_q.original;
  assign up_fnumlo   = up_q.fnumlo;
  assign up_fnumhi   = up_q.fnumhi;
  assign up_inst     = up_q.inst;
  assign rhy_en      = rhy_en_q;
  assign rhy_kon     = rhy_kon_q;

endmodule

// File: tb/tb_jtopll_wrdec.sv
// Self-checking bench for jtopll_wrdec with randomized cen and an 18-slot round.
module tb_jtopll_wrdec;

  localparam int AW  = 12;
  localparam int LIM = 400;

  logic       clk = 1'b0, rst = 1'b1, cen = 1'b0, zero = 1'b0;
  logic       cs_n = 1'b1, wr_n = 1'b1, addr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       busy, up_fnumlo, up_fnumhi, up_inst, up_original, rhy_en;
  logic [7:0] reg_din;
  logic [1:0] sel_group;
  logic [2:0] sel_sub;
  logic [4:0] rhy_kon;
  logic [17:0] obs;

  int n_cmp = 0;
  int n_bad = 0;
  int slot  = 0;

  jtopll_wrdec #(.ADDR_WAIT(AW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .zero(zero),
    .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .din(din),
    .busy(busy), .reg_din(reg_din), .sel_group(sel_group), .sel_sub(sel_sub),
    .up_fnumlo(up_fnumlo), .up_fnumhi(up_fnumhi), .up_inst(up_inst),
    .up_original(up_original), .rhy_en(rhy_en), .rhy_kon(rhy_kon)
  );

  assign obs = {busy, up_original, up_fnumlo, up_fnumhi, up_inst, sel_group, sel_sub, reg_din};

  initial forever #5 clk = ~clk;

  // Slot counter advances on each cen tick; zero marks slot 0 of 18.
  initial forever begin
    @(negedge clk);
    if (cen) slot = (slot == 17) ? 0 : slot + 1;
    cen  = ($urandom_range(0, 3) != 0);
    zero = (slot == 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Reference decode from the register map: {orig,lo,hi,inst,group[1:0],sub[2:0]}.
  function automatic logic [8:0] ref_dec(input int a);
    int c, h;
    c = a % 16;
    h = a / 16;
    if (a < 8) return {4'b1000, 2'd0, 3'(a)};
    if (c < 9 && h >= 1 && h <= 3)
      return {(h == 1) ? 4'b0100 : (h == 2) ? 4'b0010 : 4'b0001, 2'(c / 3), 3'(c % 3)};
    return 9'd0;
  endfunction

  task automatic step(output bit t, output bit z);
    @(posedge clk);
    t = cen;
    z = cen && zero;
    #1;
  endtask

  task automatic bus_press(input logic a, input logic [7:0] d);
    @(negedge clk);
    @(negedge clk);
    cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
  endtask

  task automatic bus_release();
    cs_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic wait_idle();
    bit t, z;
    int cyc = 0;
    while (busy !== 1'b0 && cyc < LIM) begin step(t, z); cyc++; end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL wait_idle: busy=%b want 0 within %0d cycles", busy, LIM);
    end
  endtask

  task automatic addr_phase(input logic [7:0] a);
    bit t, z;
    int ticks = 0, cyc = 0;
    bus_press(1'b0, a); step(t, z); bus_release();
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL await_start: busy=%b want 1", busy); end
    while (ticks < AW && cyc < LIM) begin
      step(t, z); cyc++;
      if (t) ticks++;
      n_cmp++;
      if (busy !== (ticks < AW)) begin
        n_bad++; $display("FAIL await_busy: ticks=%0d busy=%b want %b", ticks, busy, (ticks < AW));
      end
    end
  endtask

  // Data write to a strobe address; optional data write injected during HOLD.
  task automatic data_strobe(input logic [7:0] a, input logic [7:0] d, input bit inject);
    bit t, z;
    int zt = 0, cyc = 0, inj = 0;
    logic [8:0]  e;
    logic [17:0] ex;
    e = ref_dec(int'(a));
    bus_press(1'b1, d); step(t, z); bus_release();
    do begin
      ex = {(zt < 2), (zt < 2) ? e[8:5] : 4'b0000, e[4:0], d};
      n_cmp++;
      if (obs !== ex) begin
        n_bad++; $display("FAIL strobe a=%h zt=%0d: got %h want %h", a, zt, obs, ex);
      end
      if (zt >= 2) break;
      step(t, z); cyc++;
      if (z) zt++;
      if (inj == 1) begin bus_release(); inj = 2; end
      if (inject && zt == 1 && inj == 0) begin
        cs_n = 1'b0; wr_n = 1'b0; addr = 1'b1; din = 8'h77; inj = 1;
      end
    end while (cyc < LIM);
    bus_release();
    if (zt < 2) begin
      n_cmp++; n_bad++; $display("FAIL strobe_timeout: zero ticks=%0d want 2", zt);
    end
  endtask

  task automatic test_reset();
    bit t, z;
    repeat (3) step(t, z);
    n_cmp++;
    if ({obs, rhy_en, rhy_kon} !== 24'd0) begin
      n_bad++; $display("FAIL reset_state: got %h want 0", {obs, rhy_en, rhy_kon});
    end
    @(negedge clk); rst = 1'b0;
    step(t, z);
    n_cmp++;
    if ({obs, rhy_en, rhy_kon} !== 24'd0) begin
      n_bad++; $display("FAIL post_reset: got %h want 0", {obs, rhy_en, rhy_kon});
    end
  endtask

  task automatic test_strobe_random();
    logic [7:0] a;
    int ty;
    addr_phase(8'h15);
    data_strobe(8'h15, 8'hA5, 1'b0);
    for (int i = 0; i < 6; i++) begin
      ty = $urandom_range(0, 3);
      a  = (ty == 0) ? 8'($urandom_range(0, 7)) : 8'(ty * 16 + $urandom_range(0, 8));
      addr_phase(a);
      data_strobe(a, 8'($urandom), 1'b0);
    end
  endtask

  task automatic test_drop_in_hold();
    addr_phase(8'h33);
    data_strobe(8'h33, 8'h5C, 1'b1);
  endtask

  task automatic test_rhythm();
    bit t, z;
    logic [7:0] d;
    addr_phase(8'h0E);
    for (int k = 0; k < 3; k++) begin
      d = (k == 0) ? 8'h3F : 8'($urandom);
      bus_press(1'b1, d); step(t, z); bus_release();
      n_cmp++;
      if ({rhy_en, rhy_kon} !== {d[5], d[4:0]}) begin
        n_bad++; $display("FAIL rhythm: got %h want %h", {rhy_en, rhy_kon}, {d[5], d[4:0]});
      end
      repeat (3) begin
        n_cmp++;
        if (obs[17:13] !== 5'd0) begin
          n_bad++; $display("FAIL rhythm_nobusy: busy/up=%b want 0", obs[17:13]);
        end
        step(t, z);
      end
    end
    bus_press(1'b0, 8'h0E); step(t, z); bus_release();
    d = 8'($urandom) ^ {2'b00, rhy_en, rhy_kon} ^ 8'h3F;
    bus_press(1'b1, d); step(t, z); bus_release();
    n_cmp++;
    if ({busy, rhy_en, rhy_kon} !== {1'b1, d[5], d[4:0]}) begin
      n_bad++; $display("FAIL rhythm_busy: got %h want %h", {busy, rhy_en, rhy_kon}, {1'b1, d[5], d[4:0]});
    end
    wait_idle();
  endtask

  task automatic test_long_write();
    bit t, z;
    int ticks = 0;
    logic [7:0] d1, d2;
    bus_press(1'b0, 8'h0E);
    for (int i = 0; i < 56; i++) begin
      step(t, z);
      if (i == 50) bus_release();
      if (i > 0 && t) ticks++;
      n_cmp++;
      if (busy !== (ticks < AW)) begin
        n_bad++; $display("FAIL long_addr_busy: cyc=%0d busy=%b want %b", i, busy, (ticks < AW));
      end
    end
    wait_idle();
    d1 = 8'($urandom);
    d2 = d1 ^ 8'h21;
    bus_press(1'b1, d1);
    for (int i = 0; i < 50; i++) begin
      step(t, z);
      if (i == 10) din = d2;
      n_cmp++;
      if ({busy, rhy_en, rhy_kon} !== {1'b0, d1[5], d1[4:0]}) begin
        n_bad++; $display("FAIL long_rhy: cyc=%0d got %h want %h", i, {busy, rhy_en, rhy_kon}, {1'b0, d1[5], d1[4:0]});
      end
    end
    bus_release();
  endtask

  task automatic test_ignored();
    bit t, z;
    logic [7:0] lst [8];
    lst = '{8'h19, 8'h1F, 8'h29, 8'h3A, 8'h08, 8'h0D, 8'h40, 8'hFF};
    for (int i = 0; i < 8; i++) begin
      addr_phase(lst[i]);
      bus_press(1'b1, 8'($urandom)); step(t, z); bus_release();
      for (int k = 0; k < 30; k++) begin
        n_cmp++;
        if (obs[17:13] !== 5'd0) begin
          n_bad++; $display("FAIL ignored a=%h: busy/up=%b want 0", lst[i], obs[17:13]);
        end
        step(t, z);
      end
    end
  endtask

  task automatic test_reset_hold();
    bit t, z;
    int cyc = 0;
    addr_phase(8'h0E);
    bus_press(1'b1, 8'h2A); step(t, z); bus_release();
    addr_phase(8'h03);
    bus_press(1'b1, 8'hC3); step(t, z); bus_release();
    z = 1'b0;
    while (!z && cyc < LIM) begin step(t, z); cyc++; end
    n_cmp++;
    if ({busy, up_original, sel_sub, rhy_en} !== {1'b1, 1'b1, 3'd3, 1'b1}) begin
      n_bad++; $display("FAIL pre_reset_hold: got %b want 1_1_011_1", {busy, up_original, sel_sub, rhy_en});
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({obs, rhy_en, rhy_kon} !== 24'd0) begin
      n_bad++; $display("FAIL async_reset: got %h want 0", {obs, rhy_en, rhy_kon});
    end
    @(negedge clk); rst = 1'b0;
    data_strobe(8'h00, 8'h9E, 1'b0);
    addr_phase(8'h03);
    data_strobe(8'h03, 8'h61, 1'b0);
  endtask

  initial begin
    test_reset();
    test_strobe_random();
    test_drop_in_hold();
    test_rhythm();
    test_long_write();
    test_ignored();
    test_reset_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
